// File: rtl/flappy_cpu.sv
// flappy_cpu: per-frame game engine. On each GPU swap it advances bird and pipe
// physics, then streams the frame's draw ops to the GPU over valid/ready.
module flappy_cpu #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int PIPE_COUNT   = 3,
  parameter int PIPE_SPACING = 240,
  parameter int PIPE_W       = 60,
  parameter int GAP_H        = 140,
  parameter int GAP_MIN      = 40,
  parameter int BIRD_X       = 100,
  parameter int BIRD_SIZE    = 20,
  parameter int GRAVITY      = 1,
  parameter int JUMP_VEL     = 10,
  parameter int MAX_FALL     = 12,
  parameter int PIPE_SPEED   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        btn,
  input  logic        swap,
  output logic [59:0] op,
  output logic        op_valid,
  input  logic        op_ready,
  output logic        lose,
  output logic [9:0]  score
);

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [10:0] width;
    logic [10:0] height;
    logic        color;
    logic        mem_en;
    logic [10:0] mem_addr;
    logic [2:0]  scale;
  } gpu_op_t;

  typedef enum logic [1:0] {S_EMIT, S_WAIT_SWAP, S_UPDATE, S_LOST} state_t;

  localparam int OP_N  = 2 + 2 * PIPE_COUNT;
  localparam int IDX_W = $clog2(OP_N + 1);
  localparam logic signed [11:0] BIRD_Y0   = 12'((SCREEN_H - BIRD_SIZE) / 2);
  localparam logic        [15:0] LFSR_SEED = 16'hACE1;

  state_t             r_state, w_state_next;
  logic [IDX_W-1:0]   r_idx;
  gpu_op_t            r_op;
  logic               r_op_valid;
  logic               r_lose;
  logic [9:0]         r_score;
  logic signed [11:0] r_bird_y;
  logic signed [7:0]  r_vel;
  logic               r_jump_req;
  logic               r_btn_d;
  logic [15:0]        r_lfsr;
  logic [11:0]        r_pipe_x [PIPE_COUNT];
  logic [11:0]        r_gap_y  [PIPE_COUNT];

  assign op       = r_op;
  assign op_valid = r_op_valid;
  assign lose     = r_lose;
  assign score    = r_score;

  // ---------------- op list candidates ----------------
  logic [11:0] w_pipe_w [PIPE_COUNT];
  gpu_op_t     w_cand   [OP_N];
  logic        w_vis    [OP_N];

  always_comb begin
    // NOTE: every combinationally written signal gets a default first, so no path infers a latch.
    for (int j = 0; j < OP_N; j++) begin
      w_cand[j] = '0;
      w_vis[j]  = 1'b0;
    end
    for (int i = 0; i < PIPE_COUNT; i++) begin
      w_pipe_w[i] = (12'(SCREEN_W) - r_pipe_x[i] < 12'(PIPE_W)) ?
                    12'(SCREEN_W) - r_pipe_x[i] : 12'(PIPE_W);
    end

    w_cand[0].width  = 11'(SCREEN_W);
    w_cand[0].height = 11'(SCREEN_H);
    w_vis[0]         = (w_cand[0].height != '0);

    w_cand[1].x      = 11'(BIRD_X);
    w_cand[1].y      = r_bird_y[10:0];
    w_cand[1].width  = 11'(BIRD_SIZE);
    w_cand[1].height = 11'(BIRD_SIZE);
    w_cand[1].color  = 1'b1;
    w_vis[1]         = (w_cand[1].height != '0);

    for (int i = 0; i < PIPE_COUNT; i++) begin
      w_cand[2+2*i].x      = r_pipe_x[i][10:0];
      w_cand[2+2*i].width  = w_pipe_w[i][10:0];
      w_cand[2+2*i].height = r_gap_y[i][10:0];
      w_cand[2+2*i].color  = 1'b1;
      w_vis[2+2*i]         = (r_pipe_x[i] < 12'(SCREEN_W)) && (r_gap_y[i] != '0);

      w_cand[3+2*i].x      = r_pipe_x[i][10:0];
      w_cand[3+2*i].y      = 11'(r_gap_y[i] + 12'(GAP_H));
      w_cand[3+2*i].width  = w_pipe_w[i][10:0];
      w_cand[3+2*i].height = 11'(12'(SCREEN_H) - r_gap_y[i] - 12'(GAP_H));
      w_cand[3+2*i].color  = 1'b1;
      w_vis[3+2*i]         = (r_pipe_x[i] < 12'(SCREEN_W)) &&
                             (12'(SCREEN_H) - r_gap_y[i] - 12'(GAP_H) != '0);
    end
  end

  // First visible op at or after the current index; hidden ops cost no cycle.
  logic             w_found;
  logic [IDX_W-1:0] w_sel;

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int j = OP_N - 1; j >= 0; j--) begin
      if (IDX_W'(j) >= r_idx && w_vis[j]) begin
        w_found = 1'b1;
        w_sel   = IDX_W'(j);
      end
    end
  end

  // ---------------- frame physics ----------------
  logic signed [8:0]     w_vel_sum;
  logic signed [7:0]     w_vel_next;
  logic signed [11:0]    w_y_sum;
  logic [11:0]           w_y_next;
  logic [11:0]           w_px_next  [PIPE_COUNT];
  logic [11:0]           w_gap_next [PIPE_COUNT];
  logic [PIPE_COUNT-1:0] w_pass;
  logic [PIPE_COUNT-1:0] w_crash;
  logic                  w_floor;
  logic [10:0]           w_score_sum;
  logic [9:0]            w_score_next;
  logic                  w_lfsr_fb;
  logic                  w_btn_rise;

  assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_btn_rise = btn && !r_btn_d;

  always_comb begin
    w_vel_sum  = {r_vel[7], r_vel} + 9'(GRAVITY);
    w_vel_next = r_jump_req ? 8'(-JUMP_VEL) :
                 (w_vel_sum > $signed(9'(MAX_FALL))) ? 8'(MAX_FALL) : w_vel_sum[7:0];
    w_y_sum    = r_bird_y + {{4{w_vel_next[7]}}, w_vel_next};
    w_y_next   = w_y_sum[11] ? 12'd0 : w_y_sum;
    w_floor    = (13'(w_y_next) + 13'(BIRD_SIZE)) >= 13'(SCREEN_H);

    w_score_sum = 11'(r_score);
    for (int i = 0; i < PIPE_COUNT; i++) begin
      if (r_pipe_x[i] < 12'(PIPE_SPEED)) begin
        w_px_next[i]  = r_pipe_x[i] + 12'(PIPE_COUNT * PIPE_SPACING - PIPE_SPEED);
        w_gap_next[i] = 12'(GAP_MIN) + {4'd0, r_lfsr[7:0]};
      end else begin
        w_px_next[i]  = r_pipe_x[i] - 12'(PIPE_SPEED);
        w_gap_next[i] = r_gap_y[i];
      end
      w_pass[i]  = (13'(r_pipe_x[i]) + 13'(PIPE_W) >= 13'(BIRD_X)) &&
                   (13'(w_px_next[i]) + 13'(PIPE_W) <  13'(BIRD_X));
      w_crash[i] = (13'(w_px_next[i]) < 13'(BIRD_X + BIRD_SIZE)) &&
                   (13'(w_px_next[i]) + 13'(PIPE_W) > 13'(BIRD_X)) &&
                   !((w_y_next >= w_gap_next[i]) &&
                     (13'(w_y_next) + 13'(BIRD_SIZE) <= 13'(w_gap_next[i]) + 13'(GAP_H)));
      w_score_sum = w_score_sum + 11'(w_pass[i]);
    end
    w_score_next = (w_score_sum > 11'd1023) ? 10'd1023 : w_score_sum[9:0];
  end

  // ---------------- control FSM ----------------
  logic w_load, w_do_update, w_do_restart;

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_do_update  = 1'b0;
    w_do_restart = 1'b0;
    unique case (r_state)
      S_EMIT: begin
        w_load = !r_op_valid || op_ready;
        if (w_load && !w_found) w_state_next = S_WAIT_SWAP;
      end
      S_WAIT_SWAP: if (swap) w_state_next = r_lose ? S_LOST : S_UPDATE;
      S_UPDATE: begin
        w_do_update  = 1'b1;
        w_state_next = S_EMIT;
      end
      S_LOST: begin
        w_do_restart = r_jump_req;
        w_state_next = S_EMIT;
      end
      default: w_state_next = S_EMIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    r_state <= S_EMIT;
    else if (ce) r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx      <= '0;
      r_op       <= '0;
      r_op_valid <= 1'b0;
      r_lose     <= 1'b0;
      r_score    <= '0;
      r_bird_y   <= BIRD_Y0;
      r_vel      <= '0;
      r_jump_req <= 1'b0;
      r_btn_d    <= 1'b0;
      r_lfsr     <= LFSR_SEED;
      // NOTE: the pipe arrays are a handful of flops, not a RAM, so they take the async reset.
      for (int i = 0; i < PIPE_COUNT; i++) begin
        r_pipe_x[i] <= 12'(SCREEN_W + i * PIPE_SPACING);
        r_gap_y[i]  <= 12'(GAP_MIN);
      end
    end else if (ce) begin
      // NOTE: state uses non-blocking assignments; later ones in this block deliberately override earlier ones.
      r_lfsr  <= {r_lfsr[14:0], w_lfsr_fb};
      r_btn_d <= btn;
      if (w_do_update || w_do_restart) r_jump_req <= w_btn_rise;
      else                             r_jump_req <= r_jump_req || w_btn_rise;

      if (w_load) begin
        if (w_found) begin
          r_op       <= w_cand[w_sel];
          r_op_valid <= 1'b1;
          r_idx      <= w_sel + IDX_W'(1);
        end else begin
          r_op       <= '0;
          r_op_valid <= 1'b0;
          r_idx      <= '0;
        end
      end

      if (w_do_update) begin
        r_vel    <= w_vel_next;
        r_bird_y <= w_y_next;
        r_score  <= w_score_next;
        r_lose   <= r_lose | w_floor | (|w_crash);
        for (int i = 0; i < PIPE_COUNT; i++) begin
          r_pipe_x[i] <= w_px_next[i];
          r_gap_y[i]  <= w_gap_next[i];
        end
      end

      if (w_do_restart) begin
        r_lose   <= 1'b0;
        r_score  <= '0;
        r_bird_y <= BIRD_Y0;
        r_vel    <= '0;
        r_lfsr   <= LFSR_SEED;
        for (int i = 0; i < PIPE_COUNT; i++) begin
          r_pipe_x[i] <= 12'(SCREEN_W + i * PIPE_SPACING);
          r_gap_y[i]  <= 12'(GAP_MIN);
        end
      end
    end
  end

endmodule

// File: tb/tb_flappy_cpu.sv
// tb_flappy_cpu: directed bench for flappy_cpu with hand-computed bird heights,
// pipe ops, scoring and game-over frames.
module tb_flappy_cpu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        btn;
  logic        swap;
  logic [59:0] op;
  logic        op_valid;
  logic        op_ready;
  logic        lose;
  logic [9:0]  score;

  flappy_cpu dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .btn      (btn),
    .swap     (swap),
    .op       (op),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .lose     (lose),
    .score    (score)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [59:0] ops [16];
  int          n_ops;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [59:0] mk_op(input int x, input int y, input int w, input int h,
                                        input bit c);
    return {11'(x), 11'(y), 11'(w), 11'(h), c, 1'b0, 11'd0, 3'd0};
  endfunction

  // Waits for the frame's first op, then accepts ops until op_valid drops.
  task automatic collect();
    int guard = 0;
    n_ops = 0;
    while (!op_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("frame_start", 64'(op_valid), 64'd1);
    guard = 0;
    while (op_valid && guard < 40) begin
      if (n_ops < 16) ops[n_ops] = op;
      n_ops++;
      guard++;
      @(negedge clk);
    end
    check("frame_end", 64'(op_valid), 64'd0);
  endtask

  task automatic run_frame(input bit jump);
    if (jump) begin
      btn = 1'b1;
      @(negedge clk);
      btn = 1'b0;
    end
    swap = 1'b1;
    @(negedge clk);
    swap = 1'b0;
    collect();
  endtask

  function automatic int bird_y();
    return int'(ops[1][48:38]);
  endfunction

  function automatic int pipe_x();
    return int'(ops[2][59:49]);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    rst = 1'b0; ce = 1'b1; btn = 1'b0; swap = 1'b0; op_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_op",       64'(op),       64'd0);
    check("rst_op_valid", 64'(op_valid), 64'd0);
    check("rst_lose",     64'(lose),     64'd0);
    check("rst_score",    64'(score),    64'd0);

    // Frame 0: background, then a stalled bird op, then nothing.
    rst   = 1'b1;
    guard = 0;
    while (!op_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("bg_op", 64'(op), 64'(mk_op(0, 0, 640, 480, 1'b0)));
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    check("bird_op", 64'(op), 64'(mk_op(100, 230, 20, 20, 1'b1)));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_op",    64'(op),       64'(mk_op(100, 230, 20, 20, 1'b1)));
      check("stall_valid", 64'(op_valid), 64'd1);
    end
    op_ready = 1'b1;
    @(negedge clk);
    check("list_done", 64'(op_valid), 64'd0);
    repeat (5) @(negedge clk);
    check("idle_no_op", 64'(op_valid), 64'd0);

    // Free fall: pipe 0 enters the screen at x=638.
    run_frame(1'b0);
    check("f1_nops",   64'(n_ops),   64'd4);
    check("f1_bird_y", 64'(bird_y()), 64'd231);
    check("f1_top",    64'(ops[2]),  64'(mk_op(638, 0, 2, 40, 1'b1)));
    check("f1_bot",    64'(ops[3]),  64'(mk_op(638, 180, 2, 300, 1'b1)));
    run_frame(1'b0);
    check("f2_bird_y", 64'(bird_y()), 64'd233);
    run_frame(1'b0);
    check("f3_bird_y", 64'(bird_y()), 64'd236);
    check("f3_top",    64'(ops[2]),  64'(mk_op(634, 0, 6, 40, 1'b1)));

    // Clock enable low across a swap: nothing moves.
    ce   = 1'b0;
    swap = 1'b1;
    @(negedge clk);
    swap = 1'b0;
    repeat (3) @(negedge clk);
    ce = 1'b1;
    repeat (6) @(negedge clk);
    check("ce_frozen", 64'(op_valid), 64'd0);

    run_frame(1'b1);
    check("jump_bird_y", 64'(bird_y()), 64'd226);
    run_frame(1'b0);
    check("after_jump_y", 64'(bird_y()), 64'd217);
    check("after_jump_lose", 64'(lose), 64'd0);

    // Mid-game reset, then fall to the floor.
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst2_valid", 64'(op_valid), 64'd0);
    rst = 1'b1;
    collect();
    check("rst2_nops",   64'(n_ops),    64'd2);
    check("rst2_bird_y", 64'(bird_y()), 64'd230);
    for (int k = 1; k <= 25; k++) begin
      run_frame(1'b0);
      if (k == 12) check("fall12_y", 64'(bird_y()), 64'd308);
      if (k == 24) begin
        check("fall24_y",    64'(bird_y()), 64'd452);
        check("fall24_lose", 64'(lose),     64'd0);
      end
      if (k == 25) begin
        check("fall25_y",    64'(bird_y()), 64'd464);
        check("fall25_lose", 64'(lose),     64'd1);
        check("fall25_px",   64'(pipe_x()), 64'd590);
      end
    end
    run_frame(1'b0);
    check("frozen_y",    64'(bird_y()), 64'd464);
    check("frozen_px",   64'(pipe_x()), 64'd590);
    check("frozen_nops", 64'(n_ops),    64'd4);
    check("frozen_lose", 64'(lose),     64'd1);
    run_frame(1'b1);
    check("restart_y",     64'(bird_y()), 64'd230);
    check("restart_lose",  64'(lose),     64'd0);
    check("restart_score", 64'(score),    64'd0);
    check("restart_nops",  64'(n_ops),    64'd2);

    // Hover around y=175..230 (below the gap) until pipe 0 reaches the bird.
    for (int k = 1; k <= 261; k++) begin
      run_frame((k - 1) % 21 == 0);
      if (k == 21) check("hover21_y", 64'(bird_y()), 64'd230);
      if (k == 260) begin
        check("hit260_y",    64'(bird_y()), 64'd178);
        check("hit260_lose", 64'(lose),     64'd0);
      end
      if (k == 261) begin
        check("hit261_y",     64'(bird_y()), 64'd176);
        check("hit261_px",    64'(pipe_x()), 64'd118);
        check("hit261_lose",  64'(lose),     64'd1);
        check("hit261_score", 64'(score),    64'd0);
      end
    end
    run_frame(1'b1);
    check("restart2_y",    64'(bird_y()), 64'd230);
    check("restart2_lose", 64'(lose),     64'd0);

    // Climb to y=150, then hover at 95..150 inside the gap and pass all three pipes.
    for (int k = 1; k <= 541; k++) begin
      run_frame((k <= 8) || ((k >= 9) && ((k - 9) % 21 == 0)));
      if (k == 8)   check("climb8_y",   64'(bird_y()), 64'd150);
      if (k == 29)  check("hover29_y",  64'(bird_y()), 64'd150);
      if (k == 300) check("score300",   64'(score),    64'd0);
      if (k == 301) check("score301",   64'(score),    64'd1);
      if (k == 421) check("score421",   64'(score),    64'd2);
      if (k == 541) begin
        check("score541", 64'(score), 64'd3);
        check("lose541",  64'(lose),  64'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
